// File: rtl/dcc_pkg.sv
// dcc_pkg: shared state type and constants for the DCC packet serializer.
package dcc_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_PREAMBLE, ST_SEP, ST_BYTE, ST_STOP} dcc_ser_state_t;
  localparam logic DCC_SEP_BIT = 1'b0;
  localparam logic DCC_STOP_BIT = 1'b1;
  localparam logic [7:0] DCC_IDLE_ADDR = 8'hFF;
  localparam logic [7:0] DCC_IDLE_DATA = 8'h00;
  localparam logic [2:0] DCC_MIN_LEN = 3'd2;
endpackage

// File: rtl/dcc_ack_sync.sv
// dcc_ack_sync: two-flop synchronizer plus rising-edge detect for the encoder ack.
module dcc_ack_sync (
  input  logic clk,
  input  logic reset,
  input  logic ack_async,
  output logic ack_rise
);
  logic s1, s2, s3;
  always_ff @(posedge clk or posedge reset)
    if (reset) {s1, s2, s3} <= 3'b000;
    else {s1, s2, s3} <= {ack_async, s1, s2};
  assign ack_rise = s2 & ~s3;
endmodule

// File: rtl/dcc_packet_serializer.sv
// dcc_packet_serializer: turns a DCC packet into preamble/separator/byte/stop bits paced by the encoder ack.
// Optional DCC_IDLE_PACKET_EN sends DCC idle packets instead of bare ones while idle.
module dcc_packet_serializer
  import dcc_pkg::*;
#(
  parameter int PREAMBLE_BITS = 14,
  parameter int MAX_BYTES = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8*MAX_BYTES-1:0] pkt_data,
  input  logic [2:0]             pkt_len,
  input  logic                   pkt_valid,
  output logic                   pkt_ready,
  output logic                   pkt_err,
  output logic                   pkt_done,
  output logic                   busy,
  input  logic                   bit_ack,
  output logic                   next_bit
);
  logic ack_rise;
  dcc_ack_sync u_sync (.clk(clk), .reset(reset), .ack_async(bit_ack), .ack_rise(ack_rise));
  dcc_ser_state_t state;
  logic [8*MAX_BYTES-1:0] data_q;
  logic [2:0] len_q, idx;
  logic [7:0] csum, shift, cur_byte;
  logic [4:0] pre_cnt;
  logic [3:0] bit_cnt;
  logic data_byte, len_bad;
`ifdef DCC_IDLE_PACKET_EN
  logic idle_pkt;
`endif
  assign data_byte = idx < len_q;
  assign len_bad = (pkt_len < DCC_MIN_LEN) || (pkt_len > 3'(MAX_BYTES));
  // once idx passes the last data byte the checksum is what goes out
  always_comb begin
    cur_byte = csum;
    for (int i = 0; i < MAX_BYTES; i++)
      if (data_byte && idx == 3'(i)) cur_byte = data_q[8*i +: 8];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      next_bit <= 1'b1;
      pkt_ready <= 1'b0;
      pkt_err <= 1'b0;
      pkt_done <= 1'b0;
      busy <= 1'b0;
      data_q <= '0;
      len_q <= '0;
      idx <= '0;
      csum <= '0;
      shift <= '0;
      pre_cnt <= '0;
      bit_cnt <= '0;
`ifdef DCC_IDLE_PACKET_EN
      idle_pkt <= 1'b0;
`endif
    end else begin
      pkt_err <= 1'b0;
      pkt_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          pkt_ready <= 1'b1;
          // an ack in this cycle only consumes the idle 1; the preamble starts in full
          if (pkt_valid && pkt_ready) begin
            if (len_bad) pkt_err <= 1'b1;
            else begin
              data_q <= pkt_data;
              len_q <= pkt_len;
              csum <= '0;
              idx <= '0;
              pre_cnt <= 5'(PREAMBLE_BITS);
              busy <= 1'b1;
              pkt_ready <= 1'b0;
              state <= ST_PREAMBLE;
`ifdef DCC_IDLE_PACKET_EN
              idle_pkt <= 1'b0;
`endif
            end
          end
`ifdef DCC_IDLE_PACKET_EN
          else if (pkt_ready) begin
            data_q <= (8*MAX_BYTES)'({DCC_IDLE_DATA, DCC_IDLE_ADDR});
            len_q <= DCC_MIN_LEN;
            csum <= '0;
            idx <= '0;
            pre_cnt <= 5'(PREAMBLE_BITS);
            pkt_ready <= 1'b0;
            idle_pkt <= 1'b1;
            state <= ST_PREAMBLE;
          end
`endif
        end
        ST_PREAMBLE: if (ack_rise) begin
          pre_cnt <= pre_cnt - 5'd1;
          if (pre_cnt == 5'd1) begin
            state <= ST_SEP;
            next_bit <= DCC_SEP_BIT;
          end
        end
        ST_SEP: if (ack_rise) begin
          shift <= cur_byte;
          next_bit <= cur_byte[7];
          bit_cnt <= 4'd8;
          if (data_byte) csum <= csum ^ cur_byte;
          state <= ST_BYTE;
        end
        ST_BYTE: if (ack_rise) begin
          shift <= shift << 1;
          bit_cnt <= bit_cnt - 4'd1;
          if (bit_cnt == 4'd1) begin
            if (data_byte) begin
              idx <= idx + 3'd1;
              state <= ST_SEP;
              next_bit <= DCC_SEP_BIT;
            end else begin
              state <= ST_STOP;
              next_bit <= DCC_STOP_BIT;
            end
          end else next_bit <= shift[6];
        end
        ST_STOP: if (ack_rise) begin
`ifdef DCC_IDLE_PACKET_EN
          pkt_done <= !idle_pkt;
`else
          pkt_done <= 1'b1;
`endif
          busy <= 1'b0;
          next_bit <= 1'b1;
          pkt_ready <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
